// File: rtl/ddr_read_return_fifo_pkg.sv
// Shared DDR parameters: data/burst/counter widths, command and init state
// encodings, and the read-return FIFO entry layout.
package ddr_read_return_fifo_pkg;

    localparam int DDR_DATA_W    = 16;
    localparam int DDR_BURST_LEN = 4;
    localparam int DDR_OVF_CNT_W = 8;

    typedef enum logic [2:0] {
        CMD_NOP,
        CMD_ACT,
        CMD_RD,
        CMD_WR,
        CMD_PRE,
        CMD_REF,
        CMD_MRS
    } ddr_cmd_e;

    typedef enum logic [2:0] {
        INIT_IDLE,
        INIT_WAIT_PWR,
        INIT_PRECHARGE,
        INIT_REFRESH,
        INIT_LOAD_MODE,
        INIT_DONE
    } ddr_init_e;

    // One stored word plus its end-of-burst marker.
    typedef struct packed {
        logic                  last;
        logic [DDR_DATA_W-1:0] data;
    } rd_entry_t;

    localparam int RD_ENTRY_W = $bits(rd_entry_t);

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/ddr_read_return_fifo_if.sv
// Read-return handshake: capture side (data_out_rdy/sys_data_r) and
// consumer side (rd_data/rd_valid/rd_last/rd_ready).
interface ddr_read_return_fifo_if;
    import ddr_read_return_fifo_pkg::*;

    logic                  data_out_rdy;
    logic [DDR_DATA_W-1:0] sys_data_r;
    logic                  rd_ready;
    logic [DDR_DATA_W-1:0] rd_data;
    logic                  rd_valid;
    logic                  rd_last;

    // master: read datapath plus consumer; slave: the FIFO itself.
    modport master (
        output data_out_rdy,
        output sys_data_r,
        output rd_ready,
        input  rd_data,
        input  rd_valid,
        input  rd_last
    );

    modport slave (
        input  data_out_rdy,
        input  sys_data_r,
        input  rd_ready,
        output rd_data,
        output rd_valid,
        output rd_last
    );

endinterface

// File: rtl/ddr_read_return_fifo_mem.sv
// Register-array storage for the read-return FIFO: one synchronous write
// port, one asynchronous read port. Contents are never reset.
module ddr_rd_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 17
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ddr_read_return_fifo.sv
// First-word-fall-through FIFO for DDR read-return words with burst-end tagging
// and sticky overflow. Define DDR_RD_FIFO_OVF_CNT_EN to build the dropped-word counter.
module ddr_read_return_fifo
    import ddr_read_return_fifo_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int BURST_WORDS = DDR_BURST_LEN
) (
    input  logic                       clk,
    input  logic                       rst,
    ddr_read_return_fifo_if.slave      bus,
    input  logic                       ovf_clr,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       ovf,
    output logic [DDR_OVF_CNT_W-1:0]   ovf_count
);

    localparam int AW     = $clog2(DEPTH);
    localparam int BEAT_W = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;

    localparam logic [AW:0]       PTR_ONE   = (AW + 1)'(1);
    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_WORDS - 1);

    if (!is_pow2(DEPTH) || DEPTH < 4 || DEPTH > 256) begin : g_bad_depth
        $error("ddr_read_return_fifo: DEPTH must be a power of two in 4..256");
    end
    if (!is_pow2(BURST_WORDS) || BURST_WORDS > DEPTH) begin : g_bad_burst
        $error("ddr_read_return_fifo: BURST_WORDS must be a power of two in 1..DEPTH");
    end

    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [BEAT_W-1:0] beat_cnt;
    logic              beat_last;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              drop;
    logic              mem_we;
    rd_entry_t         wr_entry;
    rd_entry_t         rd_entry;

    // Extra pointer MSB separates full from empty when the addresses coincide.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign level = wr_ptr - rd_ptr;

    // Fullness is judged before a same-edge pop, so a push into a full FIFO drops.
    assign push      = bus.data_out_rdy && !full;
    assign drop      = bus.data_out_rdy && full;
    assign pop       = !empty && bus.rd_ready;
    assign beat_last = (beat_cnt == BEAT_LAST);
    assign mem_we    = push && rst;

    assign wr_entry.last = beat_last;
    assign wr_entry.data = bus.sys_data_r;

    ddr_rd_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (RD_ENTRY_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wr_entry),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_entry)
    );

    assign bus.rd_valid = !empty;
    assign bus.rd_data  = rd_entry.data;
    assign bus.rd_last  = !empty && rd_entry.last;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            beat_cnt <= '0;
            ovf      <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            // A gap in data_out_rdy restarts the burst so short bursts never tag last.
            if (!bus.data_out_rdy || beat_last) begin
                beat_cnt <= '0;
            end else begin
                beat_cnt <= beat_cnt + BEAT_ONE;
            end
            if (drop) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

`ifdef DDR_RD_FIFO_OVF_CNT_EN
    logic [DDR_OVF_CNT_W-1:0] ovf_cnt;

    function automatic logic [DDR_OVF_CNT_W-1:0] sat_inc(input logic [DDR_OVF_CNT_W-1:0] v);
        return (&v) ? v : v + DDR_OVF_CNT_W'(1);
    endfunction

    // A drop on the clearing edge restarts the count at one.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf_cnt <= '0;
        end else if (drop) begin
            ovf_cnt <= ovf_clr ? DDR_OVF_CNT_W'(1) : sat_inc(ovf_cnt);
        end else if (ovf_clr) begin
            ovf_cnt <= '0;
        end
    end

    assign ovf_count = ovf_cnt;
`else
    assign ovf_count = '0;
`endif

endmodule

// File: tb/tb_ddr_read_return_fifo.sv
// Directed bench for ddr_read_return_fifo (DEPTH=16, BURST_WORDS=4) with
// hand-computed expectations.
module tb_ddr_read_return_fifo;

`ifdef DDR_RD_FIFO_OVF_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       ovf_clr;
    logic [4:0] level;
    logic       ovf;
    logic [7:0] ovf_count;

    int checks   = 0;
    int failures = 0;

    ddr_read_return_fifo_if bus_if ();

    ddr_read_return_fifo #(
        .DEPTH       (16),
        .BURST_WORDS (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if),
        .ovf_clr   (ovf_clr),
        .level     (level),
        .ovf       (ovf),
        .ovf_count (ovf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [15:0] d);
        bus_if.data_out_rdy = 1'b1;
        bus_if.sys_data_r   = d;
        tick();
    endtask

    task automatic idle();
        bus_if.data_out_rdy = 1'b0;
        bus_if.rd_ready     = 1'b0;
    endtask

    // Check head word and tag, then pop it.
    task automatic drain_check(input string tag, input logic [15:0] d, input logic last);
        bus_if.data_out_rdy = 1'b0;
        bus_if.rd_ready     = 1'b1;
        chk({tag, "_valid"}, 32'(bus_if.rd_valid), 32'd1);
        chk({tag, "_data"}, 32'(bus_if.rd_data), 32'(d));
        chk({tag, "_last"}, 32'(bus_if.rd_last), 32'(last));
        tick();
        bus_if.rd_ready = 1'b0;
    endtask

    initial begin
        int pushed;
        int popped;
        rst                 = 1'b0;
        ovf_clr             = 1'b0;
        bus_if.data_out_rdy = 1'b0;
        bus_if.sys_data_r   = 16'h0000;
        bus_if.rd_ready     = 1'b0;
        tick();
        tick();
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_valid", 32'(bus_if.rd_valid), 32'd0);
        chk("rst_last", 32'(bus_if.rd_last), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_ovfcnt", 32'(ovf_count), 32'd0);
        rst = 1'b1;

        // Four-word burst, no consumer.
        push_word(16'h1111);
        push_word(16'h2222);
        push_word(16'h3333);
        push_word(16'h4444);
        idle();
        chk("b4_level", 32'(level), 32'd4);
        chk("b4_valid", 32'(bus_if.rd_valid), 32'd1);
        chk("b4_head", 32'(bus_if.rd_data), 32'h1111);
        chk("b4_last", 32'(bus_if.rd_last), 32'd0);
        drain_check("b4_w0", 16'h1111, 1'b0);
        drain_check("b4_w1", 16'h2222, 1'b0);
        drain_check("b4_w2", 16'h3333, 1'b0);
        drain_check("b4_w3", 16'h4444, 1'b1);
        chk("b4_empty_valid", 32'(bus_if.rd_valid), 32'd0);
        chk("b4_empty_last", 32'(bus_if.rd_last), 32'd0);
        chk("b4_empty_level", 32'(level), 32'd0);

        // Fill to 16, then one dropped push.
        for (int i = 0; i < 16; i++) push_word(16'h0100 + 16'(i));
        chk("full_level", 32'(level), 32'd16);
        chk("full_ovf_pre", 32'(ovf), 32'd0);
        push_word(16'hDEAD);
        chk("ovf_level", 32'(level), 32'd16);
        chk("ovf_flag", 32'(ovf), 32'd1);
        chk("ovf_cnt1", 32'(ovf_count), CNT_EN ? 32'd1 : 32'd0);

        // Full: push and pop on the same edge; the push is dropped.
        bus_if.data_out_rdy = 1'b1;
        bus_if.sys_data_r   = 16'hBEEF;
        bus_if.rd_ready     = 1'b1;
        tick();
        idle();
        chk("fullpp_level", 32'(level), 32'd15);
        chk("fullpp_ovf", 32'(ovf), 32'd1);
        chk("fullpp_cnt", 32'(ovf_count), CNT_EN ? 32'd2 : 32'd0);
        for (int i = 1; i < 16; i++)
            drain_check($sformatf("fill_w%0d", i), 16'h0100 + 16'(i), (i % 4) == 3);
        chk("fill_empty", 32'(bus_if.rd_valid), 32'd0);

        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("clr_ovf", 32'(ovf), 32'd0);
        chk("clr_cnt", 32'(ovf_count), 32'd0);

        // Half full: push and pop together keeps level and order.
        for (int i = 0; i < 8; i++) push_word(16'h0200 + 16'(i));
        bus_if.rd_ready = 1'b1;
        push_word(16'h0208);
        idle();
        chk("half_level", 32'(level), 32'd8);
        chk("half_head", 32'(bus_if.rd_data), 32'h0201);
        for (int i = 1; i < 9; i++)
            drain_check($sformatf("half_w%0d", i), 16'h0200 + 16'(i), (i % 4) == 3);

        // Short burst of 2, gap, burst of 4: only the 6th word is tagged.
        push_word(16'h0A01);
        push_word(16'h0A02);
        idle();
        tick();
        push_word(16'h0B01);
        push_word(16'h0B02);
        push_word(16'h0B03);
        push_word(16'h0B04);
        idle();
        drain_check("brst_w1", 16'h0A01, 1'b0);
        drain_check("brst_w2", 16'h0A02, 1'b0);
        drain_check("brst_w3", 16'h0B01, 1'b0);
        drain_check("brst_w4", 16'h0B02, 1'b0);
        drain_check("brst_w5", 16'h0B03, 1'b0);
        drain_check("brst_w6", 16'h0B04, 1'b1);

        // 20 pushes with a consumer ready every other cycle; pointers wrap.
        pushed = 0;
        popped = 0;
        for (int cyc = 0; cyc < 80 && popped < 20; cyc++) begin
            bus_if.data_out_rdy = (pushed < 20);
            bus_if.sys_data_r   = 16'(pushed);
            bus_if.rd_ready     = ((cyc % 2) == 0) || (pushed >= 20);
            if (bus_if.rd_valid && bus_if.rd_ready) begin
                chk($sformatf("wrap_w%0d", popped), 32'(bus_if.rd_data), 32'(popped));
                popped++;
            end
            if (pushed < 20) pushed++;
            tick();
        end
        idle();
        chk("wrap_popped", 32'(popped), 32'd20);
        chk("wrap_level", 32'(level), 32'd0);
        chk("wrap_ovf", 32'(ovf), 32'd0);

        // Reset with 7 words stored; data_out_rdy during reset is ignored.
        for (int i = 0; i < 7; i++) push_word(16'h0300 + 16'(i));
        idle();
        chk("prerst_level", 32'(level), 32'd7);
        rst                 = 1'b0;
        bus_if.data_out_rdy = 1'b1;
        bus_if.sys_data_r   = 16'h7777;
        tick();
        rst = 1'b1;
        idle();
        chk("midrst_level", 32'(level), 32'd0);
        chk("midrst_valid", 32'(bus_if.rd_valid), 32'd0);
        push_word(16'hABCD);
        idle();
        chk("postrst_valid", 32'(bus_if.rd_valid), 32'd1);
        chk("postrst_head", 32'(bus_if.rd_data), 32'hABCD);
        chk("postrst_level", 32'(level), 32'd1);
        chk("postrst_last", 32'(bus_if.rd_last), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ddr_read_return_fifo.md
DDR_READ_RETURN_FIFO -- requirements
Module: ddr_read_return_fifo

Interface
REQ-001 Parameter DEPTH, default 16, FIFO depth in words; SHALL be a power of two, 4..256.
REQ-002 Parameter BURST_WORDS, default 4, 16-bit words per read burst; SHALL be a power of two, 1..DEPTH.
REQ-003 Port clk  in  1  system clock; single clock domain, all logic on posedge clk.
REQ-004 Port rst  in  1  reset, synchronous, active-low.
REQ-005 Port data_out_rdy  in  1  qualifier from the read datapath; sys_data_r is valid on each cycle it is high.
REQ-006 Port sys_data_r  in  16  captured read word {high byte, low byte}.
REQ-007 Port rd_ready  in  1  consumer accepts rd_data this cycle.
REQ-008 Port ovf_clr  in  1  clears the overflow flag (and counter, if compiled in).
REQ-009 Port rd_data  out  16  head-of-FIFO word.
REQ-010 Port rd_valid  out  1  FIFO non-empty; rd_data and rd_last are valid.
REQ-011 Port rd_last  out  1  head word is the final word of a burst.
REQ-012 Port level  out  log2(DEPTH)+1  current word count.
REQ-013 Port ovf  out  1  sticky: at least one word was dropped.
REQ-014 Port ovf_count  out  8  saturating count of dropped words.

Function
REQ-015 Push: on a clk edge where data_out_rdy=1 and the FIFO is not full, {beat_last, sys_data_r} SHALL be written at wr_ptr and wr_ptr SHALL increment.
REQ-016 Pop: on a clk edge where rd_valid=1 and rd_ready=1, rd_ptr SHALL increment.
REQ-017 Output is first-word-fall-through: rd_data/rd_last SHALL reflect the entry at rd_ptr with zero cycles of latency after the pointer update. A pushed word SHALL appear on rd_valid the cycle after the push edge.
REQ-018 Pointers SHALL be log2(DEPTH)+1 bits and wrap modulo 2*DEPTH. Empty is wr_ptr==rd_ptr. Full is when the addresses are equal and the MSBs differ.
REQ-019 level SHALL equal wr_ptr-rd_ptr (modulo arithmetic), range 0..DEPTH, and SHALL be registered-consistent with the pointers.
REQ-020 Push and pop on the same edge when full: the pop SHALL occur, the push SHALL be dropped (counted as overflow), and level SHALL decrement by 1.
REQ-021 Push and pop on the same edge when neither full nor empty: both SHALL occur and level SHALL be unchanged.
REQ-022 When empty, rd_ready SHALL be ignored, and a same-cycle push SHALL be accepted normally.
REQ-023 Beat counter: it SHALL be log2(BURST_WORDS) bits. It SHALL increment on every cycle with data_out_rdy=1, whether or not the push was accepted, and SHALL wrap to 0. beat_last SHALL be 1 when the counter equals BURST_WORDS-1.
REQ-024 The beat counter SHALL reset to 0 on any cycle with data_out_rdy=0, so a short burst never carries rd_last.
REQ-025 Overflow: a cycle with data_out_rdy=1 while full (after applying REQ-020) SHALL set ovf=1 on the next edge. ovf SHALL be held until ovf_clr=1.
REQ-026 When ovf_clr and a new overflow occur on the same edge, the overflow SHALL win and ovf SHALL be 1.
REQ-027 When rd_valid=0, rd_data and rd_last SHALL be don't-care to the consumer, but rd_last SHALL be driven 0.

Reset
REQ-028 While rst=0 at a clk edge, the following SHALL be cleared: wr_ptr, rd_ptr, beat counter, ovf, and ovf_count. Result: rd_valid=0, rd_last=0, level=0, ovf=0, ovf_count=0.
REQ-029 Memory contents SHALL NOT be reset. A reset mid-burst or mid-drain SHALL discard all stored words.
REQ-030 data_out_rdy SHALL be ignored on any edge where rst=0.

Configuration
REQ-031 With macro DDR_RD_FIFO_OVF_CNT_EN defined, ovf_count SHALL increment by 1 per dropped word and saturate at 255. It SHALL be cleared by ovf_clr, and an increment SHALL win over a same-edge clear (result 1).
REQ-032 Without DDR_RD_FIFO_OVF_CNT_EN, ovf_count SHALL be tied to 0 and no counter flops SHALL be inferred. The ovf flag SHALL be unaffected.

Structure
REQ-033 The burst length, data width (16), and ovf_count width (8) constants SHALL live in the shared DDR parameters package alongside the command/init state encodings.
REQ-034 Storage SHALL be a sub-module ddr_rd_fifo_mem with a register array of DEPTH x 17 bits, one synchronous write port, and one asynchronous read port. The pointer, flag, and beat logic SHALL stay in the top module.

Verification
REQ-035 Reset, then 4 cycles of data_out_rdy=1 with data 0x1111..0x4444 and rd_ready=0. Required: level=4, rd_valid=1, rd_data=0x1111; rd_last=1 only when the head is 0x4444.
REQ-036 Fill to DEPTH=16, then 1 more push. Required: level=16, ovf=1, ovf_count=1 (macro on) or 0 (macro off), and the dropped word is never output.
REQ-037 Full FIFO, push and pop on the same edge. Required: level=15 and ovf=1. Also, half-full FIFO, push and pop on the same edge: level unchanged and the data order is preserved.
REQ-038 Burst of 2 words, data_out_rdy low for 1 cycle, then a burst of 4. Required: no rd_last on the first 2 words, and rd_last on the 6th word only.
REQ-039 Push 20 words while popping every other cycle. Required: pointers wrap correctly, output order is 0..19, and no spurious ovf.
REQ-040 Assert rst=0 for one edge with level=7. Required: level=0 and rd_valid=0 on the next cycle, then a push of 0xABCD appears as head one cycle later.
